result_buffer: RTL and testbench

RESULT_BUFFER -- requirements
Module: result_buffer

---
 rtl/result_buffer.sv | 161 ++++++++++++++++
 tb/tb_result_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_buffer.sv
// -----------------------------------------------------------------------------
// result_buffer
//
// First-word-fall-through FIFO for the results coming out of an upstream ALU.
// The oldest stored word is always presented on data_o, and valid_o tells the
// consumer that it is real. The consumer takes the word by raising ready_i
// while valid_o is high.
//
// A push that arrives while the buffer is full is dropped, unless a pop
// happens in the same cycle. A dropped push sets the sticky overflow_o flag,
// which stays set until rst_i or flush_i.
//
// Optional feature:
//   RESULT_BUFFER_BYPASS_EN - when defined, an empty buffer forwards data_i and
//   dvalid_i straight to data_o and valid_o in the same cycle. If the consumer
//   is ready in that cycle, the word is consumed without being stored. When
//   the macro is undefined, no combinational path exists from data_i or
//   dvalid_i to any output.
//
// Parameters:
//   DataWidth - width of each buffered result word
//   Depth     - number of entries (power of two, >= 2)
//
// Ports:
//   clk_i      in   clock, rising edge
//   rst_i      in   synchronous active-high reset
//   data_i     in   result word from the ALU
//   dvalid_i   in   data_i valid (push request)
//   flush_i    in   synchronous clear of contents and flags
//   ready_i    in   consumer accepts data_o this cycle
//   data_o     out  oldest buffered word, '0 when valid_o is low
//   valid_o    out  data_o holds a valid word
//   full_o     out  count equals Depth
//   empty_o    out  count equals 0
//   count_o    out  number of stored entries, 0..Depth
//   overflow_o out  sticky, a push was dropped while full
// -----------------------------------------------------------------------------
module result_buffer #(
    parameter int DataWidth = 8,
    parameter int Depth     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DataWidth-1:0]       data_i,
    input  logic                       dvalid_i,
    input  logic                       flush_i,
    input  logic                       ready_i,
    output logic [DataWidth-1:0]       data_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       overflow_o
);

    localparam int PtrWidth   = $clog2(Depth);
    localparam int CountWidth = PtrWidth + 1;

    // Storage. Not reset: an entry is only ever read while it holds live data.
    logic [DataWidth-1:0]  mem [Depth];

    logic [PtrWidth-1:0]   wr_ptr_reg;
    logic [PtrWidth-1:0]   rd_ptr_reg;
    logic [CountWidth-1:0] count_reg;
    logic                  overflow_reg;

    logic [CountWidth-1:0] count_next;
    logic                  empty;
    logic                  full;
    logic                  push_en;
    logic                  pop_en;
    logic                  drop;
    logic                  bypass_take;

    // Status comes only from registered state.
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CountWidth'(Depth));

    // -------------------------------------------------------------------------
    // Push / pop decisions
    // -------------------------------------------------------------------------
    always_comb begin
        bypass_take = 1'b0;
`ifdef RESULT_BUFFER_BYPASS_EN
        // An empty buffer hands the incoming word straight to a ready consumer.
        bypass_take = empty && dvalid_i && ready_i;
`endif
        // A pop is only possible from stored data.
        pop_en  = !empty && ready_i;
        // A pop in the same cycle frees the slot a full buffer needs.
        push_en = dvalid_i && (!full || pop_en) && !bypass_take;
        drop    = dvalid_i && full && !pop_en;

        count_next = count_reg;
        unique case ({push_en, pop_en})
            2'b10:   count_next = count_reg + CountWidth'(1);
            2'b01:   count_next = count_reg - CountWidth'(1);
            default: count_next = count_reg;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control state. rst_i takes priority over flush_i, which takes priority
    // over push/pop activity in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            // Depth is a power of two, so the natural pointer roll-over
            // wraps from Depth-1 to 0 with no gap.
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PtrWidth'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PtrWidth'(1);
            end
            count_reg <= count_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage write. A push coinciding with rst_i or flush_i is ignored.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (push_en && !rst_i && !flush_i) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        valid_o = !empty;
        data_o  = empty ? '0 : mem[rd_ptr_reg];
`ifdef RESULT_BUFFER_BYPASS_EN
        if (empty) begin
            valid_o = dvalid_i;
            data_o  = dvalid_i ? data_i : '0;
        end
`endif
    end

    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count_reg;
    assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_result_buffer
//
// Directed, self-checking bench for result_buffer (DataWidth=8, Depth=4).
// Inputs change 1 ns after a rising edge. Outputs are checked either 1 ns
// after an edge (registered effects) or 1 ns after the inputs change
// (combinational effects).
// -----------------------------------------------------------------------------
module tb_result_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       dvalid;
    logic       flush;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected stream of words for the wrap test
    logic [7:0] exp_q [$];

    result_buffer #(
        .DataWidth(8),
        .Depth(4)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .data_i    (data_in),
        .dvalid_i  (dvalid),
        .flush_i   (flush),
        .ready_i   (ready),
        .data_o    (data_out),
        .valid_o   (valid),
        .full_o    (full),
        .empty_o   (empty),
        .count_o   (count),
        .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; dvalid = 1'b0; flush = 1'b0; ready = 1'b0; data_in = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        data_in = d; dvalid = 1'b1;
        tick();
        dvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dvalid = 1'b0; flush = 1'b0; ready = 1'b0; data_in = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_valid",    32'(valid),    32'd0);
        check("rst_data",     32'(data_out), 32'h00);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        $display("reset: valid=%0d empty=%0d count=%0d", valid, empty, count);

        // Three pushes, consumer stalled
        push(8'h11); push(8'h22); push(8'h33);
        check("p3_count", 32'(count),    32'd3);
        check("p3_data",  32'(data_out), 32'h11);
        check("p3_valid", 32'(valid),    32'd1);
        check("p3_full",  32'(full),     32'd0);
        $display("push3: count=%0d data=%h", count, data_out);

        // Fill, overflow, drain
        do_reset();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        check("fill_full",  32'(full),  32'd1);
        check("fill_count", 32'(count), 32'd4);
        check("fill_ovf0",  32'(overflow), 32'd0);
        push(8'h05);
        check("drop_ovf",   32'(overflow), 32'd1);
        check("drop_count", 32'(count),    32'd4);
        $display("overflow: count=%0d overflow=%0d", count, overflow);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("drain_data", 32'(data_out), 32'(i));
            check("drain_valid", 32'(valid), 32'd1);
            $display("pop: data=%h", data_out);
            tick();
        end
        ready = 1'b0;
        check("drain_empty", 32'(empty),    32'd1);
        check("drain_valid0", 32'(valid),   32'd0);
        check("drain_data0", 32'(data_out), 32'h00);
        check("ovf_sticky",  32'(overflow), 32'd1);
        // ready while empty must do nothing
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("idle_ready_count", 32'(count), 32'd0);

        // Full buffer: simultaneous push and pop over many cycles (pointer wrap)
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            push(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        for (int i = 0; i < 10; i++) begin
            data_in = 8'hA0 + 8'(i); dvalid = 1'b1; ready = 1'b1;
            #1;
            check("wrap_data", 32'(data_out), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            exp_q.push_back(8'hA0 + 8'(i));
            tick();
            check("wrap_count", 32'(count), 32'd4);
            $display("push+pop full: in=%h count=%0d", data_in, count);
        end
        dvalid = 1'b0;
        while (exp_q.size() > 0) begin
            #1;
            check("wrap_drain", 32'(data_out), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            tick();
        end
        ready = 1'b0;
        check("wrap_empty", 32'(empty),    32'd1);
        check("wrap_ovf",   32'(overflow), 32'd0);

        // Push and pop together at count 1
        do_reset();
        push(8'h41);
        data_in = 8'h42; dvalid = 1'b1; ready = 1'b1;
        tick();
        dvalid = 1'b0; ready = 1'b0;
        check("c1_count", 32'(count),    32'd1);
        check("c1_data",  32'(data_out), 32'h42);

        // Flush with simultaneous push
        do_reset();
        push(8'h21); push(8'h22);
        check("pre_flush_count", 32'(count), 32'd2);
        flush = 1'b1; dvalid = 1'b1; data_in = 8'h77;
        tick();
        flush = 1'b0; dvalid = 1'b0;
        check("flush_count", 32'(count),    32'd0);
        check("flush_empty", 32'(empty),    32'd1);
        check("flush_ovf",   32'(overflow), 32'd0);
        check("flush_valid", 32'(valid),    32'd0);
        push(8'h99);
        check("post_flush_data",  32'(data_out), 32'h99);
        check("post_flush_count", 32'(count),    32'd1);
        $display("flush: count after new push=%0d data=%h", count, data_out);

        // Flush clears a set overflow flag
        do_reset();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h05);
        check("ovf_before_flush", 32'(overflow), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("ovf_after_flush", 32'(overflow), 32'd0);

        // Empty buffer, word arrives with the consumer ready
        do_reset();
        data_in = 8'h5C; dvalid = 1'b1; ready = 1'b1;
        #1;
`ifdef RESULT_BUFFER_BYPASS_EN
        check("byp_valid_now", 32'(valid),    32'd1);
        check("byp_data_now",  32'(data_out), 32'h5C);
        tick();
        dvalid = 1'b0; ready = 1'b0;
        #1;
        check("byp_count_next", 32'(count), 32'd0);
        check("byp_valid_next", 32'(valid), 32'd0);
`else
        check("lat_valid_now", 32'(valid),    32'd0);
        check("lat_data_now",  32'(data_out), 32'h00);
        tick();
        dvalid = 1'b0; ready = 1'b0;
        #1;
        check("lat_valid_next", 32'(valid),    32'd1);
        check("lat_data_next",  32'(data_out), 32'h5C);
        check("lat_count_next", 32'(count),    32'd1);
`endif
        $display("latency: valid=%0d data=%h count=%0d", valid, data_out, count);

        // Reset during a pop
        do_reset();
        push(8'h61); push(8'h62); push(8'h63);
        check("pre_rst_count", 32'(count), 32'd3);
        ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; ready = 1'b0;
        check("midrst_count", 32'(count),    32'd0);
        check("midrst_valid", 32'(valid),    32'd0);
        check("midrst_data",  32'(data_out), 32'h00);
        $display("mid reset: count=%0d valid=%0d", count, valid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
